// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the clkdiv_bank clock-enable generator.
package clkdiv_pkg;

   // Upper bound on channels a bank is meant to carry.
   localparam int unsigned CLKDIV_MAX_CH  = 16;
   // Divisor loaded into every channel when no override is given.
   localparam int unsigned CLKDIV_DEF_DIV = 50;

   // Width of a channel-select field; never narrower than one bit.
   function automatic int unsigned clkdiv_sel_w(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One clock-enable channel: counter, active divisor, one-deep pending divisor,
// registered tick and 50 %-duty scaled clock. A pending divisor only replaces
// the active one at a terminal count, on disable/sync, or while parked.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = CLKDIV_DEF_DIV
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sync_i,
   input  logic             en_i,
   input  logic             wr_en_i,
   input  logic [CNT_W-1:0] wr_div_i,
   output logic             pend_o,
   output logic             tick_o,
   output logic             sclk_o,
   output logic [CNT_W-1:0] cnt_o
);

   typedef logic [CNT_W-1:0] cnt_t;

   cnt_t cnt_q, cnt_d;
   cnt_t div_q, div_d;
   cnt_t pend_div_q, pend_div_d;
   logic pend_q, pend_d;
   logic sclk_q, sclk_d;
   logic tick_q, tick_d;
   logic terminal;
   logic apply;

   // Terminal count of a running channel; a zero divisor never terminates.
   assign terminal = (div_q != '0) && (cnt_q == div_q - cnt_t'(1));

   // Next state: sync > enable > count; pending divisor swaps in at safe points.
   always_comb begin
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_div_d = pend_div_q;
      pend_d     = pend_q;
      sclk_d     = sclk_q;
      tick_d     = 1'b0;
      apply      = 1'b0;

      if (sync_i || !en_i) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
         apply  = 1'b1;
      end else if (div_q == '0) begin
         // Parked: hold sclk, keep counter at zero.
         cnt_d = '0;
         apply = 1'b1;
      end else if (terminal) begin
         cnt_d  = '0;
         sclk_d = ~sclk_q;
         tick_d = 1'b1;
         apply  = 1'b1;
      end else begin
         cnt_d = cnt_q + cnt_t'(1);
      end

      if (apply && pend_q) begin
         div_d  = pend_div_q;
         pend_d = 1'b0;
      end

      // Writes are only granted while nothing is pending, so they never
      // collide with the apply above.
      if (wr_en_i) begin
         pend_div_d = wr_div_i;
         pend_d     = 1'b1;
      end
   end

   // Channel state registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         div_q      <= cnt_t'(DEFAULT_DIV);
         pend_div_q <= '0;
         pend_q     <= 1'b0;
         sclk_q     <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_div_q <= pend_div_d;
         pend_q     <= pend_d;
         sclk_q     <= sclk_d;
         tick_q     <= tick_d;
      end
   end

   assign pend_o = pend_q;
   assign tick_o = tick_q;
   assign sclk_o = sclk_q;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/clkdiv_bank.sv
// Multi-channel clock-enable generator. Each channel divides the system clock
// by a run-time programmable divisor written through a valid/ready port.
// Optional feature: define CLKDIV_SYNC_EN to add the sync port, which
// phase-aligns every channel in one cycle.
module clkdiv_bank
   import clkdiv_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = CLKDIV_DEF_DIV
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_CH-1:0]                 enable,
   input  logic                              cfg_valid,
   output logic                              cfg_ready,
   input  logic [clkdiv_sel_w(NUM_CH)-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]                  cfg_div,
   output logic [NUM_CH-1:0]                 tick,
   output logic [NUM_CH-1:0]                 scaled_clk,
   output logic [NUM_CH*CNT_W-1:0]           count
`ifdef CLKDIV_SYNC_EN
   ,
   input  logic                              sync
`endif
);

   logic [NUM_CH-1:0] pend_flag;
   logic [NUM_CH-1:0] wr_en;
   logic              sync_on;

`ifdef CLKDIV_SYNC_EN
   assign sync_on = sync;
`else
   assign sync_on = 1'b0;
`endif

   // Per-channel write strobe; an out-of-range cfg_ch selects nobody.
   always_comb begin
      wr_en = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         wr_en[i] = cfg_valid && (32'(cfg_ch) == i) && !pend_flag[i];
      end
   end

   // Ready mirrors the selected channel's free slot; out-of-range is always ready.
   always_comb begin
      cfg_ready = 1'b1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (32'(cfg_ch) == i) begin
            cfg_ready = ~pend_flag[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clkdiv_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_i    (clock),
         .rst_i    (reset),
         .sync_i   (sync_on),
         .en_i     (enable[g]),
         .wr_en_i  (wr_en[g]),
         .wr_div_i (cfg_div),
         .pend_o   (pend_flag[g]),
         .tick_o   (tick[g]),
         .sclk_o   (scaled_clk[g]),
         .cnt_o    (count[g*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Self-checking bench for clkdiv_bank: directed scenarios plus random traffic,
// each compared every cycle against a modulo-arithmetic reference model.
module tb_clkdiv_bank;

   localparam int NCH = 5;
   localparam int W   = 8;
   localparam int DEF = 50;
   localparam int SW  = 3;
   localparam int VW  = 1 + 2 * NCH + NCH * W;

   logic             clock     = 1'b0;
   logic             reset     = 1'b1;
   logic [NCH-1:0]   enable    = '0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [SW-1:0]    cfg_ch    = '0;
   logic [W-1:0]     cfg_div   = '0;
   logic [NCH-1:0]   tick;
   logic [NCH-1:0]   scaled_clk;
   logic [NCH*W-1:0] count;
   logic             sync      = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   clkdiv_bank #(
      .NUM_CH      (NCH),
      .CNT_W       (W),
      .DEFAULT_DIV (DEF)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .tick       (tick),
      .scaled_clk (scaled_clk),
      .count      (count)
`ifdef CLKDIV_SYNC_EN
      ,
      .sync       (sync)
`endif
   );

   // Reference model: phase = cycles since last wrap, modulo the divisor.
   int m_cnt [NCH];
   int m_div [NCH];
   int m_pdiv[NCH];
   bit m_pend[NCH];
   bit m_sclk[NCH];
   bit m_tick[NCH];

   function automatic void model_step();
      bit acc;
      bit apply;
      for (int i = 0; i < NCH; i++) begin
         acc       = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
         apply     = 1'b0;
         m_tick[i] = 1'b0;
         if (reset) begin
            m_cnt[i]  = 0;
            m_div[i]  = DEF;
            m_pdiv[i] = 0;
            m_pend[i] = 1'b0;
            m_sclk[i] = 1'b0;
            acc       = 1'b0;
         end else if (sync || !enable[i]) begin
            m_cnt[i]  = 0;
            m_sclk[i] = 1'b0;
            apply     = 1'b1;
         end else if (m_div[i] == 0) begin
            m_cnt[i] = 0;
            apply    = 1'b1;
         end else begin
            m_cnt[i] = (m_cnt[i] + 1) % m_div[i];
            if (m_cnt[i] == 0) begin
               m_tick[i] = 1'b1;
               m_sclk[i] = !m_sclk[i];
               apply     = 1'b1;
            end
         end
         if (apply && m_pend[i]) begin
            m_div[i]  = m_pdiv[i];
            m_pend[i] = 1'b0;
         end
         if (acc) begin
            m_pdiv[i] = int'(cfg_div);
            m_pend[i] = 1'b1;
         end
      end
   endfunction

   always @(posedge clock) model_step();

   function automatic bit model_ready();
      int c;
      c = int'(cfg_ch);
      if (c >= NCH) return 1'b1;
      return !m_pend[c];
   endfunction

   function automatic logic [VW-1:0] model_vec();
      logic [NCH-1:0]   t;
      logic [NCH-1:0]   s;
      logic [NCH*W-1:0] c;
      for (int i = 0; i < NCH; i++) begin
         t[i]         = m_tick[i];
         s[i]         = m_sclk[i];
         c[i*W +: W]  = W'(m_cnt[i]);
      end
      return {model_ready(), t, s, c};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {cfg_ready, tick, scaled_clk, count};
   endfunction

   task automatic do_reset();
      reset     = 1'b1;
      enable    = '0;
      cfg_valid = 1'b0;
      sync      = 1'b0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = '0; cfg_valid = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (count !== '0 || tick !== '0 || scaled_clk !== '0 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: count=%h tick=%b sclk=%b ready=%b, need zeros and ready=1",
                  count, tick, scaled_clk, cfg_ready);
      end
      reset = 1'b0; enable = '1;
      @(negedge clock);
      cfg_valid = 1'b1; cfg_ch = 1; cfg_div = 7;
      @(negedge clock);
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_pend_setup: ready=%b, need 0", cfg_ready);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (cfg_ready !== 1'b1 || count !== '0) begin
         errors++;
         $display("FAIL reset_discards: ready=%b count=%h, need 1 and 0", cfg_ready, count);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL reset_model: dut=%h model=%h", dut_vec(), model_vec());
      end
      reset = 1'b0; enable = '0;
   endtask

   task automatic test_default_div();
      int  exp_cnt;
      logic exp_tk, exp_sc;
      do_reset();
      enable = 5'b00001;
      for (int k = 1; k <= 210; k++) begin
         @(negedge clock);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL default_model k=%0d: dut=%h model=%h", k, dut_vec(), model_vec());
         end
         exp_cnt = k % DEF;
         exp_tk  = (exp_cnt == 0);
         exp_sc  = ((k / DEF) % 2) == 1;
         checks++;
         if (count[0 +: W] !== W'(exp_cnt) || tick[0] !== exp_tk || scaled_clk[0] !== exp_sc) begin
            errors++;
            $display("FAIL default_seq k=%0d: cnt=%0d tick=%b sclk=%b, need %0d %b %b",
                     k, count[0 +: W], tick[0], scaled_clk[0], exp_cnt, exp_tk, exp_sc);
         end
      end
   endtask

   task automatic test_pending_update();
      bit found;
      int low, last, nticks;
      do_reset();
      enable = 5'b00010;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clock);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL pend_model_wait: dut=%h model=%h", dut_vec(), model_vec());
         end
         if (count[W +: W] == 20) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL pend_wait: ch1 count never reached 20, got %0d", count[W +: W]);
      end
      cfg_valid = 1'b1; cfg_ch = 1; cfg_div = 3;
      low = 0; last = -1; nticks = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL pend_model k=%0d: dut=%h model=%h", k, dut_vec(), model_vec());
         end
         if (k == 0) cfg_valid = 1'b0;
         if (!cfg_ready) low++;
         if (tick[1]) begin
            if (last >= 0) begin
               checks++;
               if (k - last != 3) begin
                  errors++;
                  $display("FAIL pend_interval: got %0d cycles, need 3", k - last);
               end
            end
            last = k;
            nticks++;
         end
      end
      checks++;
      if (low != 29 || nticks != 11) begin
         errors++;
         $display("FAIL pend_latency: ready low %0d cycles, %0d ticks, need 29 and 11", low, nticks);
      end
   endtask

   task automatic test_back_to_back();
      bit done;
      int stall;
      do_reset();
      enable = '1;
      repeat (3) @(negedge clock);
      cfg_valid = 1'b1; cfg_ch = 2; cfg_div = 5;
      @(negedge clock);
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stall: ch2 ready=%b, need 0", cfg_ready);
      end
      cfg_ch = 3; cfg_div = 7;
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_other_ready: ch3 ready=%b, need 1", cfg_ready);
      end
      @(negedge clock);
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_other_accept: ch3 ready=%b after write, need 0", cfg_ready);
      end
      cfg_ch = 2; cfg_div = 2;
      done = 1'b0; stall = 0;
      for (int k = 0; k < 80 && !done; k++) begin
         @(negedge clock);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL b2b_model: dut=%h model=%h", dut_vec(), model_vec());
         end
         if (cfg_ready) done = 1'b1;
         else stall++;
      end
      checks++;
      if (!done || tick[2] !== 1'b1 || stall == 0) begin
         errors++;
         $display("FAIL b2b_release: done=%b tick2=%b stall=%0d, need 1 1 >0", done, tick[2], stall);
      end
      @(negedge clock);
      cfg_valid = 1'b0;
      repeat (30) begin
         @(negedge clock);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL b2b_after: dut=%h model=%h", dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_div_extremes();
      logic prev_s;
      int   last4;
      do_reset();
      cfg_valid = 1'b1; cfg_ch = 0; cfg_div = 1;
      @(negedge clock);
      cfg_ch = 1; cfg_div = 0;
      @(negedge clock);
      cfg_ch = 4; cfg_div = 8'hFF;
      @(negedge clock);
      cfg_valid = 1'b0;
      @(negedge clock);
      enable = '1;
      prev_s = scaled_clk[0];
      last4  = -1;
      for (int k = 1; k <= 520; k++) begin
         @(negedge clock);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL ext_model k=%0d: dut=%h model=%h", k, dut_vec(), model_vec());
         end
         checks++;
         if (tick[0] !== 1'b1 || scaled_clk[0] === prev_s) begin
            errors++;
            $display("FAIL div1 k=%0d: tick=%b sclk=%b prev=%b, need tick 1 and toggle",
                     k, tick[0], scaled_clk[0], prev_s);
         end
         prev_s = scaled_clk[0];
         checks++;
         if (count[W +: W] !== '0 || tick[1] !== 1'b0) begin
            errors++;
            $display("FAIL div0 k=%0d: cnt=%0d tick=%b, need 0 0", k, count[W +: W], tick[1]);
         end
         if (tick[4]) begin
            checks++;
            if ((last4 < 0 && k != 255) || (last4 >= 0 && k - last4 != 255)) begin
               errors++;
               $display("FAIL div_max k=%0d last=%0d: need period 255", k, last4);
            end
            last4 = k;
         end
      end
   endtask

   task automatic test_disable();
      bit found;
      int first;
      do_reset();
      enable = 5'b00001;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clock);
         if (scaled_clk[0] && count[0 +: W] == 30) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL disable_wait: never saw sclk=1 count=30");
      end
      enable[0] = 1'b0;
      @(negedge clock);
      checks++;
      if (count[0 +: W] !== '0 || scaled_clk[0] !== 1'b0 || tick[0] !== 1'b0) begin
         errors++;
         $display("FAIL disable_clear: cnt=%0d sclk=%b tick=%b, need 0 0 0",
                  count[0 +: W], scaled_clk[0], tick[0]);
      end
      repeat (3) @(negedge clock);
      enable[0] = 1'b1;
      first = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clock);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL disable_model: dut=%h model=%h", dut_vec(), model_vec());
         end
         if (tick[0] && first < 0) first = k;
      end
      checks++;
      if (first != 50) begin
         errors++;
         $display("FAIL reenable_first_tick: got %0d, need 50", first);
      end
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         @(negedge clock);
         if (count[0 +: W] == 49) found = 1'b1;
      end
      enable[0] = 1'b0;
      @(negedge clock);
      checks++;
      if (!found || tick[0] !== 1'b0 || count[0 +: W] !== '0 || scaled_clk[0] !== 1'b0) begin
         errors++;
         $display("FAIL disable_wins: found=%b tick=%b cnt=%0d sclk=%b, need 1 0 0 0",
                  found, tick[0], count[0 +: W], scaled_clk[0]);
      end
   endtask

   task automatic test_out_of_range();
      do_reset();
      enable = '1;
      for (int c = NCH; c < 8; c++) begin
         cfg_valid = 1'b1; cfg_ch = SW'(c); cfg_div = W'($urandom_range(1, 255));
         #1;
         checks++;
         if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL oor_ready ch=%0d: ready=%b, need 1", c, cfg_ready);
         end
         @(negedge clock);
      end
      cfg_valid = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         cfg_ch = SW'(c);
         #1;
         checks++;
         if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL oor_side_effect ch=%0d: ready=%b, need 1", c, cfg_ready);
         end
      end
      repeat (60) begin
         @(negedge clock);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL oor_model: dut=%h model=%h", dut_vec(), model_vec());
         end
      end
   endtask

`ifdef CLKDIV_SYNC_EN
   task automatic test_sync();
      int both;
      do_reset();
      cfg_valid = 1'b1; cfg_ch = 0; cfg_div = 4;
      @(negedge clock);
      cfg_ch = 1; cfg_div = 6;
      @(negedge clock);
      cfg_valid = 1'b0;
      @(negedge clock);
      enable = 5'b00011;
      repeat ($urandom_range(5, 25)) @(negedge clock);
      sync = 1'b1;
      @(negedge clock);
      sync = 1'b0;
      checks++;
      if (count[0 +: 2*W] !== '0 || scaled_clk[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin
         errors++;
         $display("FAIL sync_align: cnt=%h sclk=%b tick=%b, need zeros",
                  count[0 +: 2*W], scaled_clk[1:0], tick[1:0]);
      end
      both = -1;
      for (int k = 1; k <= 20 && both < 0; k++) begin
         @(negedge clock);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL sync_model: dut=%h model=%h", dut_vec(), model_vec());
         end
         if (tick[0] && tick[1]) both = k;
      end
      checks++;
      if (both != 12) begin
         errors++;
         $display("FAIL sync_coincident: got %0d, need 12", both);
      end
   endtask
`endif

   task automatic test_random();
      do_reset();
      enable = '1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clock);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL random k=%0d: dut=%h model=%h", k, dut_vec(), model_vec());
         end
         reset = ($urandom_range(0, 499) == 0);
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 31) == 0) enable[i] = ~enable[i];
         end
         cfg_valid = 1'($urandom_range(0, 1));
         cfg_ch    = SW'($urandom_range(0, 7));
         cfg_div   = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                 : W'($urandom_range(0, 6));
`ifdef CLKDIV_SYNC_EN
         sync = ($urandom_range(0, 199) == 0);
`endif
      end
      reset = 1'b0; cfg_valid = 1'b0; sync = 1'b0;
   endtask

   initial begin
      test_reset();
      test_default_div();
      test_pending_update();
      test_back_to_back();
      test_div_extremes();
      test_disable();
      test_out_of_range();
`ifdef CLKDIV_SYNC_EN
      test_sync();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete, need completion before time limit");
      $fatal(1, "watchdog");
   end

endmodule
